// File: rtl/ad9516_pkg.sv
// AD9516 configuration sequencer shared types and constants.
// Imported by the sequencer, its SPI shifter and the bus interface users.
package ad9516_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_SHIFT,
    S_GAP,
    S_FIN
  } state_t;

  localparam logic [15:0] TERM_ADDR  = 16'hFFFF;
  localparam int          FRAME_BITS = 24;
  localparam logic [2:0]  INSTR_HDR  = 3'b000;
  localparam logic [9:0]  LAST_IDX   = 10'd1023;

endpackage

// File: rtl/ad9516_cfg_seq_if.sv
// Register-table port and 3-wire SPI pins of the AD9516 sequencer.
// master = sequencer side, slave = table/device side.
interface ad9516_cfg_seq_if;

  logic [9:0]  lut_index;
  logic [24:0] lut_data;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_sdio;

  modport master (
    output lut_index,
    input  lut_data,
    output spi_cs_n,
    output spi_sclk,
    output spi_sdio
  );

  modport slave (
    input  lut_index,
    output lut_data,
    input  spi_cs_n,
    input  spi_sclk,
    input  spi_sdio
  );

endinterface

// File: rtl/ad9516_spi_tx.sv
// 24-bit MSB-first SPI write shifter with SCLK divider.
// i_load is taken only when idle; o_last flags the final clk of a frame.
module ad9516_spi_tx
  import ad9516_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [23:0] i_word,
  output logic        o_busy,
  output logic        o_last,
  output logic        o_cs_n,
  output logic        o_sclk,
  output logic        o_sdio
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

  logic        r_active;
  logic [7:0]  r_div;
  logic [4:0]  r_bit;
  logic [23:0] r_shreg;
  logic        r_cs_n;
  logic        r_sclk;
  logic        w_tick;
  logic        w_last;

  assign w_tick = r_active && (r_div == DIV_LAST);
  assign w_last = w_tick && r_sclk && (r_bit == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_cs_n   <= 1'b1;
      r_sclk   <= 1'b0;
    end else if (i_load && !r_active) begin
      r_active <= 1'b1;
      r_div    <= '0;
      r_bit    <= '0;
      r_shreg  <= i_word;
      r_cs_n   <= 1'b0;
      r_sclk   <= 1'b0;
    end else if (r_active) begin
      if (!w_tick) begin
        r_div <= r_div + 8'd1;
      end else begin
        r_div <= '0;
        if (!r_sclk) begin
          r_sclk <= 1'b1;
        end else begin
          // data moves only on the falling SCLK edge
          r_sclk <= 1'b0;
          if (w_last) begin
            r_active <= 1'b0;
            r_cs_n   <= 1'b1;
            r_shreg  <= '0;
          end else begin
            r_bit   <= r_bit + 5'd1;
            r_shreg <= {r_shreg[22:0], 1'b0};
          end
        end
      end
    end
  end

  assign o_busy = r_active;
  assign o_last = w_last;
  assign o_cs_n = r_cs_n;
  assign o_sclk = r_sclk;
  assign o_sdio = r_shreg[23];

endmodule

// File: rtl/ad9516_cfg_seq.sv
// AD9516 power-up register table sequencer: walks the table and
// issues one 24-bit SPI write per entry until the FFFF terminator.
module ad9516_cfg_seq
  import ad9516_pkg::*;
#(
  parameter int CLK_DIV      = 10,
  parameter int GAP_CYCLES   = 16,
  parameter int PWRUP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  ad9516_cfg_seq_if.master bus,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [9:0]       o_wr_count
);

  // GAP plus the following FETCH cycle give GAP_CYCLES of CS high
  localparam logic [19:0] PW_LAST =
    20'((PWRUP_CYCLES > 0) ? PWRUP_CYCLES - 1 : 0);
  localparam logic [19:0] GAP_LAST =
    20'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

  state_t      r_state;
  state_t      w_next;
  logic [19:0] r_cnt;
  logic [9:0]  r_idx;
  logic [9:0]  r_wr;
  logic        r_done;
  logic        r_err;
  logic        w_term;
  logic [23:0] w_word;
  logic        w_busy;
  logic        w_accept;
  logic        w_load;
  logic        w_cnt_run;
  logic        w_tx_busy;
  logic        w_tx_last;
  logic        w_unused;

  assign w_term   = (bus.lut_data[23:8] == TERM_ADDR);
  assign w_word   = {INSTR_HDR, bus.lut_data[20:8],
                     bus.lut_data[7:0]};
  assign w_unused = bus.lut_data[24];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_FIN: begin
        if (i_start) w_next = S_PWRUP;
      end
      S_PWRUP: begin
        if (r_cnt == PW_LAST) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (w_term)          w_next = S_FIN;
        else if (!w_tx_busy) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_tx_last) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST)
          w_next = (r_idx == LAST_IDX) ? S_FIN : S_FETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = 1'b1;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_cnt_run = 1'b0;
    unique case (r_state)
      S_IDLE, S_FIN: begin
        w_busy   = 1'b0;
        w_accept = i_start;
      end
      S_PWRUP, S_GAP: w_cnt_run = 1'b1;
      S_FETCH:        w_load    = !w_term && !w_tx_busy;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_wr   <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_next != r_state) r_cnt <= '0;
      else if (w_cnt_run)    r_cnt <= r_cnt + 20'd1;
      if (w_accept) begin
        r_idx  <= '0;
        r_wr   <= '0;
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (r_state == S_FETCH && w_term) r_done <= 1'b1;
      if (r_state == S_SHIFT && w_tx_last)
        r_wr <= r_wr + 10'd1;
      if (r_state == S_GAP && r_cnt == GAP_LAST) begin
        if (r_idx == LAST_IDX) r_err <= 1'b1;
        else                   r_idx <= r_idx + 10'd1;
      end
    end
  end

  ad9516_spi_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_word (w_word),
    .o_busy (w_tx_busy),
    .o_last (w_tx_last),
    .o_cs_n (bus.spi_cs_n),
    .o_sclk (bus.spi_sclk),
    .o_sdio (bus.spi_sdio)
  );

  assign bus.lut_index = r_idx;
  assign o_busy        = w_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_wr_count    = r_wr;

endmodule

// File: tb/tb_ad9516_cfg_seq.sv
// Directed bench for ad9516_cfg_seq: frame decode, timing,
// terminator, busy/restart, mid-frame reset and table overrun.
module tb_ad9516_cfg_seq;

  localparam int CD  = 4;
  localparam int GAP = 16;
  localparam int PW  = 5;
  localparam logic [24:0] TERM = {1'b0, 16'hFFFF, 8'h00};

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  logic busy1, done1, err1;
  logic busy2, done2, err2;
  logic [9:0] wr1, wr2;
  logic [24:0] tbl [1024];
  logic [23:0] exp3 [3];
  int n_checks = 0;
  int n_fail   = 0;

  ad9516_cfg_seq_if bus1 ();
  ad9516_cfg_seq_if bus2 ();

  always #5 clk = ~clk;

  assign bus1.lut_data = tbl[bus1.lut_index];
  assign bus2.lut_data = {1'b1, 16'h0100, 8'hA5};

  ad9516_cfg_seq #(
    .CLK_DIV(CD), .GAP_CYCLES(GAP), .PWRUP_CYCLES(PW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start1), .bus(bus1),
    .o_busy(busy1), .o_done(done1), .o_err(err1),
    .o_wr_count(wr1)
  );

  // smallest divider/gap keeps the 1024-frame overrun run short
  ad9516_cfg_seq #(
    .CLK_DIV(1), .GAP_CYCLES(1), .PWRUP_CYCLES(0)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start2), .bus(bus2),
    .o_busy(busy2), .o_done(done2), .o_err(err2),
    .o_wr_count(wr2)
  );

  int m_low = 0, m_rises = 0, m_since = 0, m_stable = 0;
  int m_high = 0, m_last_low = 0, m_last_rises = 0;
  int m_gap_last = 0, m_viol = 0, m_falls = 0, m_frames = 0;
  int m2_falls = 0;
  logic m_in = 1'b0, m_psdio = 1'b0, m_psclk = 1'b0;
  logic m2_pcs = 1'b1;
  logic [23:0] m_word = '0;
  logic [23:0] m_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_in = 1'b0; m_psdio = 1'b0; m_psclk = 1'b0;
        m_stable = 0; m2_pcs = 1'b1;
      end else begin
        if (m2_pcs && !bus2.spi_cs_n) m2_falls++;
        m2_pcs = bus2.spi_cs_n;
        m_stable = (bus1.spi_sdio === m_psdio) ? m_stable + 1 : 0;
        if (!bus1.spi_cs_n) begin
          if (!m_in) begin
            m_in = 1'b1; m_falls++; m_gap_last = m_high;
            m_low = 0; m_rises = 0; m_since = 0; m_word = '0;
          end
          m_low++;
          m_since++;
          if (bus1.spi_sclk && !m_psclk) begin
            m_word = {m_word[22:0], bus1.spi_sdio};
            m_rises++;
            m_since = 0;
            if (m_stable < CD) m_viol++;
          end else if (bus1.spi_sdio !== m_psdio &&
                       (bus1.spi_sclk || (m_rises > 0 && m_since < CD)))
            m_viol++;
        end else begin
          if (m_in) begin
            m_in = 1'b0;
            m_q.push_back(m_word);
            m_last_low = m_low;
            m_last_rises = m_rises;
            m_frames++;
            m_high = 0;
          end
          m_high++;
          if (bus1.spi_sclk || bus1.spi_sdio) m_viol++;
        end
        m_psdio = bus1.spi_sdio;
        m_psclk = bus1.spi_sclk;
      end
    end
  end

  task automatic pulse(input bit which);
    @(posedge clk);
    #1;
    if (which) start2 = 1'b1;
    else       start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic wait_fin(input bit which, input int budget,
                          output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (which ? (done2 || err2) : (done1 || err1)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fill_term();
    for (int i = 0; i < 1024; i++) tbl[i] = TERM;
  endtask

  task automatic load3();
    fill_term();
    tbl[0] = {1'b0, 16'h0000, 8'h18};
    tbl[1] = {1'b0, 16'h0232, 8'h01};
    tbl[2] = {1'b0, 16'h0018, 8'h06};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus1.spi_cs_n, bus1.spi_sclk, bus1.spi_sdio,
         busy1, done1, err1} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_pins got=%b exp=100000",
        {bus1.spi_cs_n, bus1.spi_sclk, bus1.spi_sdio,
         busy1, done1, err1});
    end
    n_checks++;
    if ({bus1.lut_index, wr1} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_counts idx=%0d wr=%0d exp=0/0",
        bus1.lut_index, wr1);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (m_falls != 0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle falls=%0d busy=%b exp=0/0",
        m_falls, busy1);
    end
  endtask

  task automatic test_table();
    bit ok;
    load3();
    m_q.delete();
    pulse(0);
    wait_fin(0, 5000, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL table_timeout got=done0 exp=done1");
    end
    n_checks++;
    if (m_q.size() != 3) begin
      n_fail++;
      $display("FAIL table_nframes got=%0d exp=3", m_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= m_q.size() || m_q[i] !== exp3[i]) begin
        n_fail++;
        $display("FAIL table_frame%0d got=%h exp=%h", i,
          (i < m_q.size()) ? m_q[i] : 24'hx, exp3[i]);
      end
    end
    n_checks++;
    if ({done1, err1, busy1} !== 3'b100 || wr1 !== 10'd3) begin
      n_fail++;
      $display("FAIL table_status d/e/b=%b wr=%0d exp=100/3",
        {done1, err1, busy1}, wr1);
    end
  endtask

  task automatic test_timing();
    bit ok;
    int v0;
    load3();
    v0 = m_viol;
    pulse(0);
    wait_fin(0, 5000, ok);
    n_checks++;
    if (!ok || m_last_low != 48 * CD) begin
      n_fail++;
      $display("FAIL timing_cs_low got=%0d exp=%0d",
        m_last_low, 48 * CD);
    end
    n_checks++;
    if (m_last_rises != 24) begin
      n_fail++;
      $display("FAIL timing_rises got=%0d exp=24", m_last_rises);
    end
    n_checks++;
    if (m_gap_last != GAP) begin
      n_fail++;
      $display("FAIL timing_gap got=%0d exp=%0d", m_gap_last, GAP);
    end
    n_checks++;
    if (m_viol != v0) begin
      n_fail++;
      $display("FAIL timing_sdio_stable got=%0d exp=0",
        m_viol - v0);
    end
  endtask

  task automatic test_addr_drop();
    bit ok;
    fill_term();
    tbl[0] = {1'b1, 16'hE232, 8'hA5};
    m_q.delete();
    pulse(0);
    wait_fin(0, 5000, ok);
    n_checks++;
    if (!ok || m_q.size() != 1 || m_q[0] !== 24'h0232A5) begin
      n_fail++;
      $display("FAIL addr_drop n=%0d got=%h exp=0232a5",
        m_q.size(), (m_q.size() > 0) ? m_q[0] : 24'hx);
    end
    n_checks++;
    if (wr1 !== 10'd1) begin
      n_fail++;
      $display("FAIL addr_drop_wr got=%0d exp=1", wr1);
    end
  endtask

  task automatic test_terminator();
    int f0;
    int n;
    fill_term();
    f0 = m_falls;
    n = 0;
    pulse(0);
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (done1) begin
        n = i;
        break;
      end
    end
    n_checks++;
    if (n != PW + 2) begin
      n_fail++;
      $display("FAIL term_latency got=%0d exp=%0d", n, PW + 2);
    end
    n_checks++;
    if (m_falls != f0 || wr1 !== 10'd0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL term_quiet falls=%0d wr=%0d busy=%b exp=0/0/0",
        m_falls - f0, wr1, busy1);
    end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    load3();
    m_q.delete();
    pulse(0);
    repeat (60) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b1 || bus1.spi_cs_n !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_midframe busy=%b cs_n=%b exp=1/0",
        busy1, bus1.spi_cs_n);
    end
    pulse(0);
    wait_fin(0, 5000, ok);
    n_checks++;
    if (!ok || m_q.size() != 3 || wr1 !== 10'd3) begin
      n_fail++;
      $display("FAIL busy_ignore n=%0d wr=%0d exp=3/3",
        m_q.size(), wr1);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= m_q.size() || m_q[i] !== exp3[i]) begin
        n_fail++;
        $display("FAIL busy_frame%0d got=%h exp=%h", i,
          (i < m_q.size()) ? m_q[i] : 24'hx, exp3[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    m_q.delete();
    pulse(0);
    @(negedge clk);
    n_checks++;
    if ({done1, busy1} !== 2'b01) begin
      n_fail++;
      $display("FAIL restart_clear d/b=%b exp=01", {done1, busy1});
    end
    wait_fin(0, 5000, ok);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!ok || i >= m_q.size() || m_q[i] !== exp3[i]) begin
        n_fail++;
        $display("FAIL replay_frame%0d got=%h exp=%h", i,
          (i < m_q.size()) ? m_q[i] : 24'hx, exp3[i]);
      end
    end
    n_checks++;
    if (done1 !== 1'b1 || wr1 !== 10'd3) begin
      n_fail++;
      $display("FAIL replay_status done=%b wr=%0d exp=1/3",
        done1, wr1);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    int f0;
    logic [9:0] wr_pre;
    load3();
    m_q.delete();
    base = m_frames;
    ok = 1'b0;
    pulse(0);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      #1;
      if (m_frames == base + 1 && m_in && m_rises == 10) begin
        ok = 1'b1;
        break;
      end
    end
    wr_pre = wr1;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!ok || wr_pre !== 10'd1) begin
      n_fail++;
      $display("FAIL rstmid_reach ok=%b wr=%0d exp=1/1", ok, wr_pre);
    end
    n_checks++;
    if ({bus1.spi_cs_n, bus1.spi_sclk, bus1.spi_sdio,
         busy1, done1, err1} !== 6'b100000 ||
        {bus1.lut_index, wr1} !== 20'd0) begin
      n_fail++;
      $display("FAIL rstmid_outputs pins=%b idx=%0d wr=%0d exp=100000/0/0",
        {bus1.spi_cs_n, bus1.spi_sclk, bus1.spi_sdio,
         busy1, done1, err1}, bus1.lut_index, wr1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = m_falls;
    repeat (100) @(negedge clk);
    n_checks++;
    if (m_falls != f0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet falls=%0d busy=%b exp=0/0",
        m_falls - f0, busy1);
    end
    m_q.delete();
    pulse(0);
    wait_fin(0, 5000, ok);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!ok || i >= m_q.size() || m_q[i] !== exp3[i]) begin
        n_fail++;
        $display("FAIL rstmid_replay%0d got=%h exp=%h", i,
          (i < m_q.size()) ? m_q[i] : 24'hx, exp3[i]);
      end
    end
  endtask

  task automatic test_no_term();
    bit ok;
    int f0;
    f0 = m2_falls;
    pulse(1);
    wait_fin(1, 60000, ok);
    n_checks++;
    if (!ok || {err2, done2, busy2} !== 3'b100) begin
      n_fail++;
      $display("FAIL noterm_status e/d/b=%b exp=100",
        {err2, done2, busy2});
    end
    n_checks++;
    if (m2_falls - f0 != 1024) begin
      n_fail++;
      $display("FAIL noterm_frames got=%0d exp=1024", m2_falls - f0);
    end
    n_checks++;
    if (bus2.lut_index !== 10'd1023 || wr2 !== 10'd0) begin
      n_fail++;
      $display("FAIL noterm_counts idx=%0d wr=%0d exp=1023/0",
        bus2.lut_index, wr2);
    end
  endtask

  initial begin
    exp3[0] = 24'h000018;
    exp3[1] = 24'h023201;
    exp3[2] = 24'h001806;
    fill_term();
    test_reset();
    test_table();
    test_timing();
    test_addr_drop();
    test_terminator();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_no_term();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
